// File: rtl/smi_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : smi_arb_pkg
//  Description : Shared types and constants for the SMI frame arbiter.
//                - arb_state_t : arbiter lock state
//                - smi_flit_t  : one flit as {last, data} at the default width
//                - c_GRANT_A / c_GRANT_B : round-robin pointer values
//  Revision    : 1.0 - initial release
// ============================================================================
package smi_arb_pkg;

    localparam int c_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCK_A = 2'd1,
        ARB_LOCK_B = 2'd2
    } arb_state_t;

    // Value held by the round-robin pointer after serving each requester.
    localparam logic c_GRANT_A = 1'b0;
    localparam logic c_GRANT_B = 1'b1;

    typedef struct packed {
        logic                    last;
        logic [c_DATA_WIDTH-1:0] data;
    } smi_flit_t;

endpackage
`default_nettype wire

// File: rtl/smi_frame_arb_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : smi_frame_arb_buffer
//  Description : Two-entry elastic buffer (output register + skid register)
//                with valid/stop handshake. Both o_stop and o_valid come
//                straight from flops, so i_stop has no combinational path
//                to o_stop.
//  Ports       : clk, nrst          - clock, async active-low reset
//                i_valid/i_data     - upstream side, o_stop back-pressure
//                o_valid/o_data     - downstream side, i_stop back-pressure
//  Revision    : 1.0 - initial release
// ============================================================================
module smi_frame_arb_buffer #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_stop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_stop
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_full;

    logic w_in_fire;
    logic w_out_free;
    logic w_skid_next;

    assign w_in_fire  = i_valid & ~r_full;
    // Output register can take a new flit this cycle.
    assign w_out_free = ~r_out_valid | ~i_stop;
    // Skid is only occupied when the output register is held and a flit
    // arrives; while the skid is full, r_full blocks new arrivals.
    assign w_skid_next = w_out_free ? (r_skid_valid & w_in_fire)
                                    : (r_skid_valid | w_in_fire);

    // Control flops. r_full comes out of reset set so that upstream is
    // held off until the first clock edge after reset release.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_full       <= 1'b1;
        end else begin
            if (w_out_free) begin
                r_out_valid <= r_skid_valid | w_in_fire;
            end
            r_skid_valid <= w_skid_next;
            r_full       <= w_skid_next;
        end
    end

    // Datapath flops carry no reset; contents only matter when flagged valid.
    always_ff @(posedge clk) begin
        if (w_out_free) begin
            r_out_data <= r_skid_valid ? r_skid_data : i_data;
        end
        if (w_in_fire && !w_out_free) begin
            r_skid_data <= i_data;
        end
    end

    assign o_stop  = r_full;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

endmodule
`default_nettype wire

// File: rtl/smi_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : smi_frame_arbiter
//  Description : Two-input, one-output frame-granular round-robin arbiter.
//                Once a requester is locked, its frame passes unbroken up to
//                the last flit; output goes through a two-entry elastic
//                buffer.
//  Ports       : clk, nrst                         - clock, async active-low reset
//                dataInValid/Last/In/StopA and ..B - requester links
//                dataOutValid/Last/Out/Stop        - downstream link
//                grantA, grantB                    - registered lock status
//  Revision    : 1.0 - initial release
// ============================================================================
module smi_frame_arbiter
    import smi_arb_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  dataInValidA,
    input  logic                  dataInLastA,
    input  logic [DATA_WIDTH-1:0] dataInA,
    output logic                  dataInStopA,
    input  logic                  dataInValidB,
    input  logic                  dataInLastB,
    input  logic [DATA_WIDTH-1:0] dataInB,
    output logic                  dataInStopB,
    output logic                  dataOutValid,
    output logic                  dataOutLast,
    output logic [DATA_WIDTH-1:0] dataOut,
    input  logic                  dataOutStop,
    output logic                  grantA,
    output logic                  grantB
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic       r_last_grant;
    logic       w_next_last_grant;
    logic       r_in_frame;
    logic       w_next_in_frame;

    logic w_lock_a;
    logic w_lock_b;
    logic w_acc_a;
    logic w_acc_b;
    logic w_buf_stop;
    logic w_buf_valid;
    logic [DATA_WIDTH:0] w_wr_flit;
    logic [DATA_WIDTH:0] w_rd_flit;

    assign w_lock_a = (r_state == ARB_LOCK_A);
    assign w_lock_b = (r_state == ARB_LOCK_B);
    assign w_acc_a  = w_lock_a & dataInValidA & ~w_buf_stop;
    assign w_acc_b  = w_lock_b & dataInValidB & ~w_buf_stop;

    assign dataInStopA = w_lock_a ? w_buf_stop : 1'b1;
    assign dataInStopB = w_lock_b ? w_buf_stop : 1'b1;
    assign w_wr_flit   = w_lock_b ? {dataInLastB, dataInB} : {dataInLastA, dataInA};

    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        w_next_in_frame   = r_in_frame;
        case (r_state)
            ARB_IDLE: begin
                if (dataInValidA && (!dataInValidB || r_last_grant == c_GRANT_B)) begin
                    w_next_state = ARB_LOCK_A;
                end else if (dataInValidB) begin
                    w_next_state = ARB_LOCK_B;
                end
            end
            ARB_LOCK_A: begin
                if (w_acc_a) begin
                    w_next_in_frame = ~dataInLastA;
                    if (dataInLastA) begin
                        // The accepting input is valid by definition, so the
                        // lock stays here unless B is waiting.
                        w_next_last_grant = c_GRANT_A;
                        w_next_state      = dataInValidB ? ARB_LOCK_B : ARB_LOCK_A;
                    end
                end else if (!r_in_frame && !dataInValidA) begin
                    // Between frames with the owner idle: hand over or release,
                    // otherwise the other requester could wait forever.
                    w_next_state = dataInValidB ? ARB_LOCK_B : ARB_IDLE;
                end
            end
            ARB_LOCK_B: begin
                if (w_acc_b) begin
                    w_next_in_frame = ~dataInLastB;
                    if (dataInLastB) begin
                        w_next_last_grant = c_GRANT_B;
                        w_next_state      = dataInValidA ? ARB_LOCK_A : ARB_LOCK_B;
                    end
                end else if (!r_in_frame && !dataInValidB) begin
                    w_next_state = dataInValidA ? ARB_LOCK_A : ARB_IDLE;
                end
            end
            default: begin
                w_next_state    = ARB_IDLE;
                w_next_in_frame = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= c_GRANT_B;
            r_in_frame   <= 1'b0;
            grantA       <= 1'b0;
            grantB       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
            r_in_frame   <= w_next_in_frame;
            grantA       <= (w_next_state == ARB_LOCK_A);
            grantB       <= (w_next_state == ARB_LOCK_B);
        end
    end

    smi_frame_arb_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_buffer (
        .clk     (clk),
        .nrst    (nrst),
        .i_valid (w_acc_a | w_acc_b),
        .i_data  (w_wr_flit),
        .o_stop  (w_buf_stop),
        .o_valid (w_buf_valid),
        .o_data  (w_rd_flit),
        .i_stop  (dataOutStop)
    );

    assign dataOutValid = w_buf_valid;
    // Last flag is qualified by valid so it reads 0 from reset onwards.
    assign dataOutLast  = w_rd_flit[DATA_WIDTH] & w_buf_valid;
    assign dataOut      = w_rd_flit[DATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_smi_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_smi_frame_arbiter
//  Description : Self-checking bench for smi_frame_arbiter. Drivers push each
//                accepted flit into a per-source expected queue; a monitor
//                pops on every downstream transfer. Flit data bit 15 carries
//                the source id so the monitor knows which queue to use.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_smi_frame_arbiter;

    logic        clk  = 1'b0;
    logic        nrst = 1'b0;
    logic        vA = 1'b0, lA = 1'b0, vB = 1'b0, lB = 1'b0, os = 1'b0;
    logic [15:0] dA = '0, dB = '0;
    logic        sA, sB, ov, ol, gA, gB;
    logic [15:0] od;

    always #5 clk = ~clk;

    smi_frame_arbiter #(.DATA_WIDTH(16)) dut (
        .clk(clk), .nrst(nrst),
        .dataInValidA(vA), .dataInLastA(lA), .dataInA(dA), .dataInStopA(sA),
        .dataInValidB(vB), .dataInLastB(lB), .dataInB(dB), .dataInStopB(sB),
        .dataOutValid(ov), .dataOutLast(ol), .dataOut(od), .dataOutStop(os),
        .grantA(gA), .grantB(gB)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic abort_drv = 1'b0;

    logic [16:0] exp_a[$];
    logic [16:0] exp_b[$];
    logic [16:0] out_log[$];
    int          out_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: per-source ordering and frame contiguity.
    logic mon_busy = 1'b0;
    logic mon_src  = 1'b0;
    always @(negedge clk) begin
        logic [16:0] got;
        logic [16:0] want;
        logic        src;
        if (!nrst) begin
            exp_a.delete();
            exp_b.delete();
            mon_busy = 1'b0;
        end else if (ov && !os) begin
            got = {ol, od};
            src = od[15];
            out_log.push_back(got);
            out_cyc.push_back(cyc);
            if (mon_busy) chk("frame_contiguous_src", {31'd0, src}, {31'd0, mon_src});
            if ((src ? exp_b.size() : exp_a.size()) == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_flit: actual 0x%0h required none (cycle %0d)", got, cyc);
            end else begin
                want = src ? exp_b.pop_front() : exp_a.pop_front();
                chk("flit_order", {15'd0, got}, {15'd0, want});
            end
            mon_busy = !ol;
            mon_src  = src;
        end
    end

    // Fairness: while a source presents a frame start, count frames the other
    // source completes; at most one may slip in before it is served.
    logic [1:0] inf = 2'b00;
    int wcnt_a = 0, wcnt_b = 0;
    always @(negedge clk) begin
        logic fa, fb;
        fa = vA && !sA;
        fb = vB && !sB;
        if (!nrst) begin
            inf = 2'b00; wcnt_a = 0; wcnt_b = 0;
        end else begin
            if (vA && !inf[0]) begin
                if (fb && lB) wcnt_a++;
                if (fa) begin chk("fair_wait_A", (wcnt_a <= 1), 1); wcnt_a = 0; end
            end
            if (vB && !inf[1]) begin
                if (fa && lA) wcnt_b++;
                if (fb) begin chk("fair_wait_B", (wcnt_b <= 1), 1); wcnt_b = 0; end
            end
            if (fa) inf[0] = !lA;
            if (fb) inf[1] = !lB;
        end
    end

    task automatic send_frame(input bit src, input int len, input logic [15:0] base,
                              input int max_gap, output int first_wait);
        first_wait = 0;
        for (int i = 0; i < len; i++) begin
            int waited;
            bit acc;
            repeat ($urandom_range(0, max_gap)) step();
            if (src) begin vB = 1'b1; lB = (i == len - 1); dB = base + 16'(i); end
            else     begin vA = 1'b1; lA = (i == len - 1); dA = base + 16'(i); end
            waited = 0;
            acc    = 1'b0;
            while (!acc && !abort_drv) begin
                @(negedge clk);
                acc = src ? (vB && !sB && nrst) : (vA && !sA && nrst);
                if (acc) begin
                    if (src) exp_b.push_back({lB, dB});
                    else     exp_a.push_back({lA, dA});
                end
                @(posedge clk);
                #1;
                waited++;
                if (!acc && waited > 3000) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL accept_timeout: src %0d actual no accept required accept", src);
                    break;
                end
            end
            if (i == 0) first_wait = waited;
            if (src) begin vB = 1'b0; lB = 1'b0; end
            else     begin vA = 1'b0; lA = 1'b0; end
            if (abort_drv || !acc) return;
        end
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        step();
        step();
        nrst = 1'b1;
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w1, w2;
        logic [16:0] t2_exp [8];
        t2_exp = '{17'h00010, 17'h10011, 17'h08020, 17'h18021,
                   17'h00014, 17'h10015, 17'h08024, 17'h18025};

        // Reset state while nrst is held low.
        step(); step();
        chk("rst_valid", ov, 0);  chk("rst_last", ol, 0);
        chk("rst_stopA", sA, 1);  chk("rst_stopB", sB, 1);
        chk("rst_grantA", gA, 0); chk("rst_grantB", gB, 0);
        nrst = 1'b1;

        // 3-flit frame from A right after reset.
        exp_a.push_back({1'b0, 16'h0001});
        exp_a.push_back({1'b0, 16'h0002});
        exp_a.push_back({1'b1, 16'h0003});
        vA = 1'b1; lA = 1'b0; dA = 16'h0001;
        step();
        chk("t1_grantA_c1", gA, 1); chk("t1_stopA_c1", sA, 0); chk("t1_stopB_c1", sB, 1);
        chk("t1_valid_c1", ov, 0);
        step();
        chk("t1_out1_valid", ov, 1); chk("t1_out1", od, 16'h0001); chk("t1_out1_last", ol, 0);
        chk("t1_stopB_c2", sB, 1);
        dA = 16'h0002;
        step();
        chk("t1_out2", od, 16'h0002); chk("t1_out2_last", ol, 0); chk("t1_stopB_c3", sB, 1);
        dA = 16'h0003; lA = 1'b1;
        step();
        chk("t1_out3", od, 16'h0003); chk("t1_out3_last", ol, 1); chk("t1_stopB_c4", sB, 1);
        vA = 1'b0; lA = 1'b0;
        step();
        chk("t1_drained", ov, 0); chk("t1_released", gA, 0);

        // Ties after reset: A first, then B without a bubble; repeat to see A win again.
        do_reset();
        out_log.delete(); out_cyc.delete();
        for (int r = 0; r < 2; r++) begin
            fork
                send_frame(1'b0, 2, 16'h0010 + 16'(4 * r), 0, w1);
                send_frame(1'b1, 2, 16'h8020 + 16'(4 * r), 0, w2);
            join
            repeat (3) step();
        end
        chk("t2_count", out_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("t2_seq", {15'd0, out_log[i]}, {15'd0, t2_exp[i]});
        chk("t2_no_bubble", out_cyc[3] - out_cyc[0], 3);

        // Downstream stall of 5 cycles mid-frame.
        out_log.delete();
        fork
            send_frame(1'b0, 6, 16'h0100, 0, w1);
            begin
                int n = 0;
                while (out_log.size() < 2 && n < 50) begin step(); n++; end
                os = 1'b1;
                step(); step(); step();
                chk("t3_stopA_full", sA, 1); chk("t3_hold_valid", ov, 1);
                chk("t3_hold_data", od, 16'h0102); chk("t3_no_drain", out_log.size(), 2);
                step(); step();
                os = 1'b0;
            end
        join
        repeat (4) step();
        chk("t3_count", out_log.size(), 6);
        for (int i = 0; i < 6; i++) chk("t3_seq", {15'd0, out_log[i]}, {16'd0, i == 5, 16'h0100 + 16'(i)} );

        // B streams 1-flit frames; A joins and is served next.
        out_log.delete(); out_cyc.delete();
        fork
            for (int i = 0; i < 10; i++) send_frame(1'b1, 1, 16'h8200 + 16'(i), 0, w1);
            begin
                repeat (6) step();
                chk("t4_grantB", gB, 1);
                send_frame(1'b0, 2, 16'h0300, 0, w2);
            end
        join
        repeat (4) step();
        chk("t4_a_wait", w2, 2);
        chk("t4_b_rate", out_cyc[4] - out_cyc[0], 4);
        chk("t4_a_next", {15'd0, out_log[6]}, {15'd0, 17'h00300});
        chk("t4_count", out_log.size(), 12);

        // Reset pulsed with two flits buffered.
        os = 1'b1;
        fork
            send_frame(1'b0, 5, 16'h0400, 0, w1);
            begin
                int n = 0;
                step(); step();
                while (!sA && n < 20) begin step(); n++; end
                chk("t5_prefull_valid", ov, 1);
                #2;
                nrst = 1'b0;
                #1;
                chk("t5_valid", ov, 0);   chk("t5_stopA", sA, 1); chk("t5_stopB", sB, 1);
                chk("t5_grantA", gA, 0);  chk("t5_grantB", gB, 0);
                abort_drv = 1'b1;
                step(); step();
            end
        join
        abort_drv = 1'b0;
        os = 1'b0;
        nrst = 1'b1;
        out_log.delete();
        fork
            send_frame(1'b0, 1, 16'h0500, 0, w1);
            send_frame(1'b1, 1, 16'h8500, 0, w2);
        join
        repeat (3) step();
        chk("t5_count", out_log.size(), 2);
        chk("t5_tie_A", {15'd0, out_log[0]}, {15'd0, 17'h10500});
        chk("t5_then_B", {15'd0, out_log[1]}, {15'd0, 17'h18500});

        // Randomized traffic: 5000 frames per source with random downstream stop.
        begin
            bit done = 1'b0;
            fork
                begin
                    fork
                        begin
                            int sa = 0;
                            for (int f = 0; f < 5000; f++) begin
                                int len = $urandom_range(1, 3);
                                send_frame(1'b0, len, {1'b0, 15'(sa)}, 2, w1);
                                sa += len;
                            end
                        end
                        begin
                            int sb = 0;
                            for (int g = 0; g < 5000; g++) begin
                                int len = $urandom_range(1, 3);
                                send_frame(1'b1, len, {1'b1, 15'(sb)}, 2, w2);
                                sb += len;
                            end
                        end
                    join
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        os = ($urandom_range(0, 3) == 0);
                        step();
                    end
                end
            join
            os = 1'b0;
            begin
                int n = 0;
                while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 100) begin step(); n++; end
            end
            chk("drain_A", exp_a.size(), 0);
            chk("drain_B", exp_b.size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
